// File: rtl/timer_pkg.sv
// Shared constants and types for the timer subsystem.
package timer_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int TIMER_WIDTH = 16;
    localparam int TIMER_NCLK  = 4;
    localparam int TIMER_CKS_W = $clog2(TIMER_NCLK);

    typedef logic [TIMER_CKS_W-1:0] cks_t;

endpackage

// File: rtl/timer_clk_sel.sv
// Count-clock select and rising-edge detect in the pclk domain.
module timer_clk_sel
    import timer_pkg::*;
#(
    parameter  int NCLK = TIMER_NCLK,
    localparam int SW   = $clog2(NCLK)
) (
    input  logic            pclk,
    input  logic            preset_n,
    input  logic [NCLK-1:0] clk_in,
    input  logic [SW-1:0]   cks,
    output logic            tick
);

    logic          sel;
    logic          last;
    logic [SW-1:0] cks_q;

    assign sel  = clk_in[cks];
    // A select change masks the edge so a switch onto a high input never counts.
    assign tick = sel & ~last & (cks == cks_q);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            last  <= 1'b0;
            cks_q <= '0;
        end else begin
            last  <= sel;
            cks_q <= cks;
        end
    end

endmodule

// File: rtl/timer_counter_gen.sv
// Parametrised up/down timer counter with load, wrap pulses and sticky flags.
// Optional TIMER_AUTO_RELOAD_EN adds input arl: wrap to tdr instead of 0/all-ones.
module timer_counter_gen
    import timer_pkg::*;
#(
    parameter  int WIDTH = TIMER_WIDTH,
    parameter  int NCLK  = TIMER_NCLK,
    localparam int SW    = $clog2(NCLK)
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic [NCLK-1:0]  clk_in,
    input  logic [SW-1:0]    cks,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] tdr,
`ifdef TIMER_AUTO_RELOAD_EN
    input  logic             arl,
`endif
    input  logic             clr_ovf,
    input  logic             clr_udf,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_d1,
    output logic             ovf_pulse,
    output logic             udf_pulse,
    output logic             ovf_sts,
    output logic             udf_sts
);

    logic             tick;
    logic             step;
    logic             set_ovf;
    logic             set_udf;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] wrap_dn;

    timer_clk_sel #(.NCLK(NCLK)) u_clk_sel (
        .pclk     (pclk),
        .preset_n (preset_n),
        .clk_in   (clk_in),
        .cks      (cks),
        .tick     (tick)
    );

    // Load outranks counting; a tick during load is dropped.
    assign step    = ~load & en & tick;
    assign set_ovf = step & (dir == DIR_UP)   & (cnt == '1);
    assign set_udf = step & (dir == DIR_DOWN) & (cnt == '0);

`ifdef TIMER_AUTO_RELOAD_EN
    assign wrap_up = arl ? tdr : '0;
    assign wrap_dn = arl ? tdr : '1;
`else
    assign wrap_up = '0;
    assign wrap_dn = '1;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt       <= '0;
            cnt_d1    <= '0;
            ovf_pulse <= 1'b0;
            udf_pulse <= 1'b0;
            ovf_sts   <= 1'b0;
            udf_sts   <= 1'b0;
        end else begin
            cnt_d1    <= cnt;
            ovf_pulse <= set_ovf;
            udf_pulse <= set_udf;
            // Set beats a coincident clear.
            ovf_sts   <= set_ovf | (ovf_sts & ~clr_ovf);
            udf_sts   <= set_udf | (udf_sts & ~clr_udf);
            if (load)
                cnt <= tdr;
            else if (step) begin
                if (set_ovf)
                    cnt <= wrap_up;
                else if (set_udf)
                    cnt <= wrap_dn;
                else if (dir == DIR_UP)
                    cnt <= cnt + 1'b1;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
